// File: rtl/pc_seq_pkg.sv
// Shared opcode fields, command/class/state encodings and fault codes for the PC sequencer.
// Pure definitions; no logic.
package pc_seq_pkg;

  localparam logic [2:0]  OP_GOTO      = 3'b101;
  localparam logic [2:0]  OP_CALL      = 3'b100;
  localparam logic [13:0] INSTR_RETURN = 14'h0008;
  localparam logic [13:0] INSTR_RETFIE = 14'h0009;
  localparam logic [3:0]  OP_BTFSC     = 4'b0110;
  localparam logic [3:0]  OP_BTFSS     = 4'b0111;
  localparam logic [5:0]  OP_DECFSZ    = 6'b001011;
  localparam logic [5:0]  OP_INCFSZ    = 6'b001111;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OVF  = 2'b01;
  localparam logic [1:0] FC_UNF  = 2'b10;

  typedef enum logic [2:0] {
    CMD_INC, CMD_SKIP, CMD_GOTO, CMD_CALL, CMD_RET, CMD_HOLD
  } cmd_t;

  typedef enum logic [2:0] {
    CL_PLAIN, CL_GOTO, CL_CALL, CL_RET, CL_RETFIE, CL_SKIP
  } iclass_t;

  typedef enum logic {S_RUN, S_FAULT} state_t;

endpackage

// File: rtl/pc_seq_decode.sv
// Classifies a 14-bit instruction into a control-flow class and extracts the jump target.
// Purely combinational, zero latency, no backpressure.
module pc_seq_decode
  import pc_seq_pkg::*;
(
  input  logic [13:0] instr,
  output logic [2:0]  cls,
  output logic [10:0] target
);

  iclass_t c;

  always_comb begin
    c = CL_PLAIN;
    if (instr == INSTR_RETURN)
      c = CL_RET;
    else if (instr == INSTR_RETFIE)
      c = CL_RETFIE;
    else if (instr[13:11] == OP_GOTO)
      c = CL_GOTO;
    else if (instr[13:11] == OP_CALL)
      c = CL_CALL;
    else if (instr[13:10] == OP_BTFSC || instr[13:10] == OP_BTFSS ||
             instr[13:8] == OP_DECFSZ || instr[13:8] == OP_INCFSZ)
      c = CL_SKIP;
  end

  assign cls    = c;
  assign target = instr[10:0];

endmodule

// File: rtl/pc_sequencer.sv
// Issues one PC command per cycle from the fetched instruction, tracks stack depth and interrupts.
// Commands are same-cycle combinational; stall/!instr_valid hold the PC; stack faults freeze until reset.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          STACK_DEPTH = 8,
  parameter logic [10:0] VECTOR      = 11'h004,
  parameter logic        GIE_RESET   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] instr,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        skip_cond,
  input  logic        irq,
  output logic        pc_branch,
  output logic        pc_direct,
  output logic        pc_push,
  output logic        pc_pop,
  output logic        pc_skip,
  output logic [10:0] pc_target,
  output logic        exec_valid,
  output logic [3:0]  stack_depth,
  output logic        in_isr,
  output logic        gie,
  output logic        fault,
  output logic [1:0]  fault_code
);

  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

  logic [2:0]  dec_cls;
  logic [10:0] dec_target;
  iclass_t     cls;

  pc_seq_decode u_decode (
    .instr  (instr),
    .cls    (dec_cls),
    .target (dec_target)
  );

  assign cls = iclass_t'(dec_cls);

  state_t     state_q, state_d;
  logic [3:0] depth_q, depth_d;
  logic       gie_q, gie_d;
  logic       isr_q, isr_d;
  logic       fault_q, fault_d;
  logic [1:0] fc_q, fc_d;
  cmd_t       cmd;
  logic       at_full, at_empty;

  assign at_full  = (depth_q == DEPTH_MAX);
  assign at_empty = (depth_q == 4'd0);

  always_comb begin
    cmd        = CMD_INC;
    pc_target  = dec_target;
    exec_valid = 1'b0;
    state_d    = state_q;
    depth_d    = depth_q;
    gie_d      = gie_q;
    isr_d      = isr_q;
    fault_d    = fault_q;
    fc_d       = fc_q;
    if (!reset) begin
      if (state_q == S_FAULT || stall || !instr_valid) begin
        cmd = CMD_HOLD;
      end else begin
        unique case (cls)
          CL_GOTO: begin
            cmd        = CMD_GOTO;
            exec_valid = 1'b1;
          end
          CL_CALL: begin
            if (at_full) begin
              cmd     = CMD_HOLD;
              state_d = S_FAULT;
              fault_d = 1'b1;
              fc_d    = FC_OVF;
            end else begin
              cmd        = CMD_CALL;
              exec_valid = 1'b1;
              depth_d    = depth_q + 4'd1;
            end
          end
          CL_RET, CL_RETFIE: begin
            if (at_empty) begin
              cmd     = CMD_HOLD;
              state_d = S_FAULT;
              fault_d = 1'b1;
              fc_d    = FC_UNF;
            end else begin
              cmd        = CMD_RET;
              exec_valid = 1'b1;
              depth_d    = depth_q - 4'd1;
              if (cls == CL_RETFIE) begin
                gie_d = 1'b1;
                isr_d = 1'b0;
              end
            end
          end
          CL_SKIP: begin
            cmd        = skip_cond ? CMD_SKIP : CMD_INC;
            exec_valid = 1'b1;
          end
          default: begin
            // Interrupt rides on a plain instruction: it still commits, and PC+1 is pushed.
            if (irq && gie_q) begin
              if (at_full) begin
                cmd     = CMD_HOLD;
                state_d = S_FAULT;
                fault_d = 1'b1;
                fc_d    = FC_OVF;
              end else begin
                cmd        = CMD_CALL;
                pc_target  = VECTOR;
                exec_valid = 1'b1;
                depth_d    = depth_q + 4'd1;
                gie_d      = 1'b0;
                isr_d      = 1'b1;
              end
            end else begin
              cmd        = CMD_INC;
              exec_valid = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      depth_q <= 4'd0;
      gie_q   <= GIE_RESET;
      isr_q   <= 1'b0;
      fault_q <= 1'b0;
      fc_q    <= FC_NONE;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      gie_q   <= gie_d;
      isr_q   <= isr_d;
      fault_q <= fault_d;
      fc_q    <= fc_d;
    end
  end

  assign pc_branch   = (cmd == CMD_GOTO) || (cmd == CMD_CALL) || (cmd == CMD_RET) || (cmd == CMD_HOLD);
  assign pc_direct   = (cmd == CMD_GOTO);
  assign pc_push     = (cmd == CMD_CALL);
  assign pc_pop      = (cmd == CMD_RET);
  assign pc_skip     = (cmd == CMD_SKIP);
  assign stack_depth = depth_q;
  assign gie         = gie_q;
  assign in_isr      = isr_q;
  assign fault       = fault_q;
  assign fault_code  = fc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: driver queues hand-computed expectations per cycle,
// a monitor pops and compares them at the falling edge.
module tb_pc_sequencer;

  localparam int INC = 0, SKIP = 1, GOTO = 2, CALL = 3, RET = 4, HOLD = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] instr = 14'h0;
  logic        instr_valid = 1'b1;
  logic        stall = 1'b0;
  logic        skip_cond = 1'b0;
  logic        irq = 1'b0;
  logic        pc_branch, pc_direct, pc_push, pc_pop, pc_skip;
  logic [10:0] pc_target;
  logic        exec_valid;
  logic [3:0]  stack_depth;
  logic        in_isr, gie, fault;
  logic [1:0]  fault_code;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .skip_cond(skip_cond), .irq(irq),
    .pc_branch(pc_branch), .pc_direct(pc_direct), .pc_push(pc_push),
    .pc_pop(pc_pop), .pc_skip(pc_skip), .pc_target(pc_target),
    .exec_valid(exec_valid), .stack_depth(stack_depth), .in_isr(in_isr),
    .gie(gie), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [4:0]  strobes;   // {branch, direct, push, pop, skip}
    logic [10:0] tgt;
    logic        ev;
    logic [3:0]  depth;
    logic        g, isr, f;
    logic [1:0]  fc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  function automatic exp_t mk(input int c, input logic [10:0] t, input logic ev,
                              input logic [3:0] d, input logic g, input logic i,
                              input logic f, input logic [1:0] fc);
    exp_t e;
    e.id      = 0;
    e.strobes = {c >= GOTO, c == GOTO, c == CALL, c == RET, c == SKIP};
    e.tgt     = t;
    e.ev      = ev;
    e.depth   = d;
    e.g       = g;
    e.isr     = i;
    e.f       = f;
    e.fc      = fc;
    return e;
  endfunction

  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, id, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [13:0] i, input logic iv, input logic st,
                      input logic sc, input logic rq, input exp_t e);
    @(posedge clk);
    #1;
    reset = r; instr = i; instr_valid = iv; stall = st; skip_cond = sc; irq = rq;
    e.id = cyc;
    cyc++;
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents a command every cycle, so each falling edge consumes one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("strobes", e.id, 32'({pc_branch, pc_direct, pc_push, pc_pop, pc_skip}), 32'(e.strobes));
        cmp("exec_valid", e.id, 32'(exec_valid), 32'(e.ev));
        if (e.strobes[3] || e.strobes[2])
          cmp("pc_target", e.id, 32'(pc_target), 32'(e.tgt));
        cmp("regs{depth,gie,isr,fault,code}", e.id,
            32'({stack_depth, gie, in_isr, fault, fault_code}),
            32'({e.depth, e.g, e.isr, e.f, e.fc}));
      end
    end
  end

  initial begin
    int wait_cyc;
    step(1, 14'h2805, 1, 0, 0, 0, mk(INC,  0, 0, 0, 1, 0, 0, 0));
    step(0, 14'h2805, 1, 0, 0, 0, mk(GOTO, 11'h005, 1, 0, 1, 0, 0, 0));
    step(0, 14'h2010, 1, 0, 0, 0, mk(CALL, 11'h010, 1, 0, 1, 0, 0, 0));
    step(0, 14'h0008, 1, 0, 0, 0, mk(RET,  0, 1, 1, 1, 0, 0, 0));
    step(0, 14'h1803, 1, 0, 1, 0, mk(SKIP, 0, 1, 0, 1, 0, 0, 0));
    step(0, 14'h1803, 1, 0, 0, 0, mk(INC,  0, 1, 0, 1, 0, 0, 0));
    step(0, 14'h0B00, 1, 0, 1, 0, mk(SKIP, 0, 1, 0, 1, 0, 0, 0));
    step(0, 14'h2010, 1, 1, 0, 0, mk(HOLD, 0, 0, 0, 1, 0, 0, 0));
    step(0, 14'h2010, 0, 0, 0, 0, mk(HOLD, 0, 0, 0, 1, 0, 0, 0));
    // irq deferred across GOTO and skip-class, taken on the plain instruction
    step(0, 14'h2805, 1, 0, 0, 1, mk(GOTO, 11'h005, 1, 0, 1, 0, 0, 0));
    step(0, 14'h1803, 1, 0, 0, 1, mk(INC,  0, 1, 0, 1, 0, 0, 0));
    step(0, 14'h0700, 1, 0, 0, 1, mk(CALL, 11'h004, 1, 0, 1, 0, 0, 0));
    step(0, 14'h0700, 1, 0, 0, 1, mk(INC,  0, 1, 1, 0, 1, 0, 0));
    step(0, 14'h0009, 1, 0, 0, 0, mk(RET,  0, 1, 1, 0, 1, 0, 0));
    step(0, 14'h0000, 1, 0, 0, 0, mk(INC,  0, 1, 0, 1, 0, 0, 0));
    // overflow
    for (int k = 0; k < 8; k++)
      step(0, 14'h2010, 1, 0, 0, 0, mk(CALL, 11'h010, 1, 4'(k), 1, 0, 0, 0));
    step(0, 14'h2010, 1, 0, 0, 0, mk(HOLD, 0, 0, 8, 1, 0, 0, 0));
    step(0, 14'h0000, 1, 0, 0, 0, mk(HOLD, 0, 0, 8, 1, 0, 1, 2'b01));
    step(0, 14'h2805, 1, 0, 0, 0, mk(HOLD, 0, 0, 8, 1, 0, 1, 2'b01));
    step(1, 14'h0000, 1, 0, 0, 0, mk(INC,  0, 0, 8, 1, 0, 1, 2'b01));
    // underflow via RETURN and RETFIE
    step(0, 14'h0008, 1, 0, 0, 0, mk(HOLD, 0, 0, 0, 1, 0, 0, 0));
    step(0, 14'h0000, 1, 0, 0, 0, mk(HOLD, 0, 0, 0, 1, 0, 1, 2'b10));
    step(1, 14'h0000, 1, 0, 0, 0, mk(INC,  0, 0, 0, 1, 0, 1, 2'b10));
    step(0, 14'h0009, 1, 0, 0, 0, mk(HOLD, 0, 0, 0, 1, 0, 0, 0));
    step(0, 14'h0000, 1, 0, 0, 0, mk(HOLD, 0, 0, 0, 1, 0, 1, 2'b10));
    step(1, 14'h0000, 1, 0, 0, 0, mk(INC,  0, 0, 0, 1, 0, 1, 2'b10));
    // reset mid-ISR
    step(0, 14'h0700, 1, 0, 0, 1, mk(CALL, 11'h004, 1, 0, 1, 0, 0, 0));
    step(1, 14'h0700, 1, 0, 0, 1, mk(INC,  0, 0, 1, 0, 1, 0, 0));
    step(0, 14'h0000, 1, 0, 0, 0, mk(INC,  0, 1, 0, 1, 0, 0, 0));
    // stall at nonzero depth keeps depth
    step(0, 14'h2010, 1, 0, 0, 0, mk(CALL, 11'h010, 1, 0, 1, 0, 0, 0));
    step(0, 14'h0008, 1, 1, 0, 0, mk(HOLD, 0, 0, 1, 1, 0, 0, 0));
    step(0, 14'h0008, 1, 0, 0, 0, mk(RET,  0, 1, 1, 1, 0, 0, 0));
    step(0, 14'h0000, 1, 0, 0, 0, mk(INC,  0, 1, 0, 1, 0, 0, 0));

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control sequencer that drives the 13-bit program counter / call-stack block.
- Decodes the 14-bit instruction fetched from asynchronous program ROM at the current PC and issues exactly one PC command per cycle: increment, skip, goto, call, return or hold.
- Tracks call-stack depth, vectors interrupts and freezes the PC on stack faults.
- Sits between program ROM, the ALU (skip condition, stall) and the PC block.

Parameters:
- STACK_DEPTH, 8, number of return-address entries in the PC stack.
- VECTOR, 11'h004, interrupt vector target.
- GIE_RESET, 1'b1, global interrupt enable value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- instr  in  14  instruction at current PC (same-cycle, async ROM)
- instr_valid  in  1  ROM data valid; 0 forces HOLD
- stall  in  1  datapath busy with multi-cycle op; forces HOLD
- skip_cond  in  1  ALU skip result for current skip-class instruction
- irq  in  1  level interrupt request
- pc_branch  out  1  PC command: 1 = non-sequential (goto/call/ret/hold)
- pc_direct  out  1  PC command: load pc_target without stack
- pc_push  out  1  PC command: push PC+1, load pc_target
- pc_pop  out  1  PC command: load popped address
- pc_skip  out  1  PC command: PC+2 (valid only with pc_branch=0)
- pc_target  out  11  jump target
- exec_valid  out  1  datapath commits current instruction this cycle
- stack_depth  out  4  live entries, 0..STACK_DEPTH
- in_isr  out  1  executing interrupt handler
- gie  out  1  global interrupt enable
- fault  out  1  sticky stack fault
- fault_code  out  2  01 overflow, 10 underflow, 00 none

Behaviour:
- Command outputs are combinational from state + inputs.
- stack_depth, gie, in_isr, fault and fault_code are registered.
- Command encodings:
  - INC = all strobes 0.
  - SKIP = pc_skip=1.
  - GOTO = branch + direct.
  - CALL = branch + push.
  - RET = branch + pop.
  - HOLD = branch only.
- Decode (instr):
  - [13:11]=101 → GOTO, target=instr[10:0].
  - [13:11]=100 → CALL, target=instr[10:0].
  - 14'h0008 → RETURN.
  - 14'h0009 → RETFIE.
  - [13:10]=0110/0111 (bit test) or [13:8]=001011/001111 (dec/inc skip) → skip-class.
  - Everything else → plain.
- Skip-class instructions: SKIP if skip_cond=1, else INC. exec_valid=1 either way.
- States:
  - RUN: normal decode and command issue.
  - FAULT: entered on stack error. Issues HOLD with exec_valid=0 every cycle. Left only by reset.
- In RUN, precedence per cycle:
  1. reset
  2. stall or !instr_valid → HOLD, exec_valid=0, no state change
  3. decoded command with exec_valid=1
- Interrupt:
  - Taken when irq=1 and gie=1 in a RUN cycle whose instruction is plain (would issue INC).
  - Instruction still executes (exec_valid=1), but the command becomes CALL with pc_target=VECTOR.
  - The pushed PC+1 is the correct return address.
  - Next cycle: gie=0, in_isr=1.
  - When the instruction is control-flow or skip-class, the interrupt is deferred to the next eligible cycle.
- RETFIE: RET plus gie←1, in_isr←0 next cycle.
- Depth accounting: CALL (including interrupt) +1; RET/RETFIE −1; updated on the command cycle.
- Overflow:
  - Condition: CALL or interrupt when stack_depth==STACK_DEPTH.
  - Command suppressed to HOLD, exec_valid=0.
  - Next cycle: FAULT, fault=1, fault_code=01.
- Underflow:
  - Condition: RET/RETFIE when stack_depth==0.
  - Same handling, fault_code=10.
- Reset (any time, including mid-ISR or FAULT): stack_depth=0, gie=GIE_RESET, in_isr=0, fault=0, fault_code=00, state RUN.
- While reset is high, command outputs are INC and exec_valid=0.

Decomposition:
- Package pc_seq_pkg:
  - Opcode field constants.
  - Command enum {CMD_INC, CMD_SKIP, CMD_GOTO, CMD_CALL, CMD_RET, CMD_HOLD}.
  - Instruction-class enum.
  - Fault code constants.
  - State enum {S_RUN, S_FAULT}.
- Sub-module pc_seq_decode: purely combinational, instr → class + target. The FSM, depth counter and interrupt logic live in pc_sequencer.

Test Plan:
- Reset, then instr=14'h2805 (GOTO 0x005) → branch=1, direct=1, pc_target=0x005, exec_valid=1, stack_depth=0.
- instr=14'h2010 (CALL 0x010), then 14'h0008 → cycle1 push=1, target=0x010, depth 0→1; cycle2 pop=1, depth 1→0.
- instr=14'h1803 (bit-test skip) with skip_cond=1 → pc_skip=1, branch=0. Same with skip_cond=0 → all strobes 0.
- gie=1, irq=1 on plain instr 14'h0700 → push=1, target=0x004, exec_valid=1; next cycle gie=0, in_isr=1, depth=1. irq held on a GOTO cycle → GOTO issued, interrupt deferred.
- 8 consecutive CALLs, then a 9th → ninth issues HOLD, exec_valid=0; next cycle fault=1, fault_code=01, HOLD persists until reset clears it.
- RETURN at depth 0 → fault_code=10. stall=1 mid-sequence → HOLD, exec_valid=0, depth unchanged.
